// File: rtl/fetch_dispatch.sv
// ---------------------------------------------------------------------------
// fetch_dispatch
//   Fetch/dispatch stage that feeds the execute FSMs (MOV, ADD, ...).
//   It reads one 16-bit word from program ROM at pc and latches it into the
//   instruction register (IR). While the word executes, IR is presented on the
//   shared `instruction` bus until the active execute FSM raises `done`.
//   Between instructions the bus carries IDLE_WORD, so every execute FSM falls
//   back to its reset state.
//
//   Optional feature macro: WATCHDOG_EN
//     defined   : an EXEC cycle counter skips an instruction that never
//                 completes. After TIMEOUT cycles the stage does pc+1, sets the
//                 sticky err flag and fetches the next word.
//     undefined : EXEC waits for done indefinitely and err is tied to 0.
//
//   Execute-side handshake (pcInc / done):
//     These are level inputs, sampled on every rising edge while in EXEC and
//     ignored in all other states. pcInc adds 1 to pc in each cycle it is high.
//     done ends the instruction: the next state is FETCH and the bus returns
//     to IDLE_WORD on that edge. A single cycle may carry both. jmpEn loads pc
//     from jmpAddr and takes priority over pcInc in the same cycle.
//
// Ports
//   clk          in   1     system clock, rising edge
//   rst          in   1     asynchronous active-low reset
//   memData      in   16    ROM read data, valid one cycle after memRd
//   memAddr      out  PC_W  ROM address (= pc)
//   memRd        out  1     ROM read strobe
//   instruction  out  16    to execute FSMs: [15:12] opcode, [11:6] p1, [5:0] p2
//   pcInc        in   1     pc increment request (EXEC only)
//   done         in   1     instruction complete (EXEC only)
//   jmpEn        in   1     load pc from jmpAddr (EXEC only)
//   jmpAddr      in   PC_W  jump target
//   pc           out  PC_W  current program counter
//   halted       out  1     high once HALT_OP has been loaded
//   err          out  1     sticky watchdog error
//   dbg_state    out  2     current FSM state (0 FETCH, 1 LOAD, 2 EXEC, 3 HALT)
// ---------------------------------------------------------------------------
module fetch_dispatch #(
   parameter int          PC_W      = 8,
   parameter logic [15:0] IDLE_WORD = 16'h0000,
   parameter logic [3:0]  HALT_OP   = 4'b1111,
   parameter int          TIMEOUT   = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [15:0]     memData,
   output logic [PC_W-1:0] memAddr,
   output logic            memRd,
   output logic [15:0]     instruction,
   input  logic            pcInc,
   input  logic            done,
   input  logic            jmpEn,
   input  logic [PC_W-1:0] jmpAddr,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            err,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_LOAD  = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] ir;
   logic [3:0]  load_op;
   logic        timeout_hit;

   assign load_op = memData[15:12];

`ifdef WATCHDOG_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] wd_cnt;
   logic             err_q;

   // LOAD always comes right before EXEC, so clearing the counter there is the
   // same as clearing it on EXEC entry.
   assign timeout_hit = (state == S_EXEC) && !done && (wd_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == S_LOAD) begin
            wd_cnt <= '0;
         end else if (state == S_EXEC) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   // No watchdog: the comparison is always false and only keeps TIMEOUT referenced.
   assign timeout_hit = (TIMEOUT < 0);
   assign err         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and the read strobe
   always_comb begin
      state_nxt = state;
      memRd     = 1'b0;
      unique case (state)
         // Reset leaves the FSM in FETCH. Gating with rst keeps the strobe low
         // during reset and raises it as soon as reset is released.
         S_FETCH: begin
            memRd     = rst;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (load_op == 4'b0000) begin
               state_nxt = S_FETCH;
            end else if (load_op == HALT_OP) begin
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (done || timeout_hit) begin
               state_nxt = S_FETCH;
            end
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase
   end

   // pc, IR and halted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc     <= '0;
         ir     <= IDLE_WORD;
         halted <= 1'b0;
      end else begin
         unique case (state)
            S_LOAD: begin
               ir <= memData;
               if (load_op == 4'b0000) begin
                  pc <= pc + PC_W'(1);
               end else if (load_op == HALT_OP) begin
                  halted <= 1'b1;
               end
            end
            S_EXEC: begin
               if (timeout_hit) begin
                  pc <= pc + PC_W'(1);
               end else if (jmpEn) begin
                  pc <= jmpAddr;
               end else if (pcInc) begin
                  pc <= pc + PC_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // IR reaches the bus only in EXEC. The mux is selected by registered state,
   // so the bus is stable for the whole instruction.
   assign instruction = (state == S_EXEC) ? ir : IDLE_WORD;
   assign memAddr     = pc;
   assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_dispatch.sv
module tb_fetch_dispatch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] mem_data = 16'h0000;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] instr;
   logic        pc_inc = 1'b0;
   logic        done_in = 1'b0;
   logic        jmp_en = 1'b0;
   logic [7:0]  jmp_addr = 8'h00;
   logic [7:0]  pc;
   logic        halted;
   logic        err;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [15:0] rom [256];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Synchronous program ROM: data is valid in the cycle after memRd.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= rom[mem_addr];
   end

   fetch_dispatch dut (
      .clk(clk), .rst(rst), .memData(mem_data), .memAddr(mem_addr), .memRd(mem_rd),
      .instruction(instr), .pcInc(pc_inc), .done(done_in), .jmpEn(jmp_en),
      .jmpAddr(jmp_addr), .pc(pc), .halted(halted), .err(err), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // pc result of one instruction: walk the cycles, a jump beats an increment.
   function automatic logic [7:0] model_pc(input logic [7:0] start, input int n,
                                           input logic [15:0] mask, input int jc,
                                           input logic [7:0] ja);
      logic [7:0] p;
      p = start;
      for (int k = 0; k < n; k++) begin
         if (k == jc) p = ja;
         else if (mask[k]) p = p + 8'd1;
      end
      return p;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b0; pc_inc = 1'b0; jmp_en = 1'b0; done_in = 1'b0; jmp_addr = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic expect_fetch(input string tag, input logic [7:0] addr);
      check({tag, "_rd"},     32'(mem_rd), 32'd1);
      check({tag, "_addr"},   32'(mem_addr), 32'(addr));
      check({tag, "_pc"},     32'(pc), 32'(addr));
      check({tag, "_instr"},  32'(instr), 32'h0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   // Entered at a negedge while in FETCH. Returns at the negedge of the next FETCH.
   task automatic run_exec(input string tag, input logic [7:0] start, input logic [15:0] word,
                           input int n, input logic [15:0] mask, input int jc,
                           input logic [7:0] ja);
      logic [7:0] p;
      p = start;
      @(negedge clk);
      check({tag, "_load_rd"},    32'(mem_rd), 32'd0);
      check({tag, "_load_instr"}, 32'(instr), 32'h0);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check({tag, "_ex_instr"}, 32'(instr), 32'(word));
         check({tag, "_ex_pc"},    32'(pc), 32'(p));
         check({tag, "_ex_rd"},    32'(mem_rd), 32'd0);
         pc_inc   = mask[k];
         jmp_en   = (k == jc);
         jmp_addr = ja;
         done_in  = (k == n - 1);
         if (k == jc) p = ja;
         else if (mask[k]) p = p + 8'd1;
      end
      @(negedge clk);
      pc_inc = 1'b0; jmp_en = 1'b0; done_in = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] word;
      int          n;
      logic [15:0] mask;
      int          jc;
      logic [7:0]  ja;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [7:0]  p;
      logic [15:0] w;
      logic [15:0] m;
      int          n;
      int          jc;
      logic [7:0]  ja;
      int          r;

      vecs[0] = '{16'h5040, 4, 16'b0010,  -1, 8'h00, 8'h01};
      vecs[1] = '{16'h1234, 1, 16'b0001,  -1, 8'h00, 8'h01};
      vecs[2] = '{16'h2001, 3, 16'b0111,  -1, 8'h00, 8'h03};
      vecs[3] = '{16'h3abc, 2, 16'b0000,  -1, 8'h00, 8'h00};
      vecs[4] = '{16'h4000, 2, 16'b0011,   1, 8'h40, 8'h40};
      vecs[5] = '{16'h6fff, 3, 16'b0110,   0, 8'h80, 8'h82};
      vecs[6] = '{16'he001, 5, 16'b10101, -1, 8'h00, 8'h03};
      vecs[7] = '{16'h7abc, 3, 16'b0001,   2, 8'h00, 8'h00};

      for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

      // ---- reset state ----
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_rd", 32'(mem_rd), 32'd0);
      check("rst_instr", 32'(instr), 32'h0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // ---- table-driven single instructions at address 0 ----
      foreach (vecs[i]) begin
         do_reset();
         rom[0] = vecs[i].word;
         expect_fetch("vec_fetch0", 8'h00);
         run_exec("vec", 8'h00, vecs[i].word, vecs[i].n, vecs[i].mask, vecs[i].jc, vecs[i].ja);
         expect_fetch("vec_next", vecs[i].exp_pc);
      end

      // ---- NOP walk plus reset in the middle of EXEC at pc=5 ----
      do_reset();
      for (int a = 0; a < 5; a++) rom[a] = 16'h0000;
      rom[5] = 16'h1111;
      for (int a = 0; a < 5; a++) begin
         expect_fetch("nop_fetch", 8'(a));
         @(negedge clk);
         @(negedge clk);
      end
      expect_fetch("nop_fetch5", 8'h05);
      @(negedge clk);
      @(negedge clk);
      check("t1_exec_instr", 32'(instr), 32'h1111);
      check("t1_exec_pc", 32'(pc), 32'h05);
      pc_inc = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("t1_pc", 32'(pc), 32'h0);
      check("t1_instr", 32'(instr), 32'h0);
      check("t1_rd", 32'(mem_rd), 32'd0);
      check("t1_halted", 32'(halted), 32'd0);
      check("t1_err", 32'(err), 32'd0);
      @(negedge clk);
      check("t1_hold_pc", 32'(pc), 32'h0);
      pc_inc = 1'b0;

      // ---- NOPs with stray control inputs, then HALT ----
      do_reset();
      rom[0] = 16'h0abc; rom[1] = 16'h0abc; rom[2] = 16'h0abc; rom[3] = 16'hf000;
      for (int a = 0; a < 3; a++) begin
         expect_fetch("t3_fetch", 8'(a));
         pc_inc = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h77; done_in = 1'b1;
         @(negedge clk);
         check("t3_load_instr", 32'(instr), 32'h0);
         @(negedge clk);
         pc_inc = 1'b0; jmp_en = 1'b0; done_in = 1'b0;
      end
      expect_fetch("t3_fetch_halt", 8'h03);
      @(negedge clk);
      @(negedge clk);
      check("t5_halted", 32'(halted), 32'd1);
      check("t5_halt_rd", 32'(mem_rd), 32'd0);
      check("t5_halt_instr", 32'(instr), 32'h0);
      pc_inc = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h55; done_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_frozen_pc", 32'(pc), 32'h03);
         check("t5_frozen_rd", 32'(mem_rd), 32'd0);
         check("t5_frozen_halted", 32'(halted), 32'd1);
      end
      pc_inc = 1'b0; jmp_en = 1'b0; done_in = 1'b0;

      // ---- pc wrap: jump to 0xFF, then increment ----
      do_reset();
      for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
      rom[0] = 16'h1000;
      rom[255] = 16'h2000;
      expect_fetch("t5_fetch0", 8'h00);
      run_exec("t5_jmp", 8'h00, 16'h1000, 1, 16'h0, 0, 8'hff);
      expect_fetch("t5_fetch_ff", 8'hff);
      run_exec("t5_inc", 8'hff, 16'h2000, 1, 16'h1, -1, 8'h00);
      expect_fetch("t5_wrap", 8'h00);

      // ---- instruction that never completes ----
      do_reset();
      rom[0] = 16'h9123;
      expect_fetch("t6_fetch", 8'h00);
      @(negedge clk);
`ifdef WATCHDOG_EN
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         check("t6_wd_instr", 32'(instr), 32'h9123);
         check("t6_wd_err0", 32'(err), 32'd0);
      end
      @(negedge clk);
      check("t6_wd_rd", 32'(mem_rd), 32'd1);
      check("t6_wd_addr", 32'(mem_addr), 32'h01);
      check("t6_wd_err", 32'(err), 32'd1);
      check("t6_wd_instr_idle", 32'(instr), 32'h0);
`else
      repeat (100) @(negedge clk);
      check("t6_still_exec", 32'(instr), 32'h9123);
      check("t6_no_rd", 32'(mem_rd), 32'd0);
      check("t6_pc", 32'(pc), 32'h00);
      check("t6_err", 32'(err), 32'd0);
`endif

      // ---- randomized programs against the instruction-level model ----
      for (int run = 0; run < 4; run++) begin
         for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 19);
            if (r < 4)        rom[a] = {4'h0, 12'($urandom)};
            else if (r == 19) rom[a] = {4'hf, 12'($urandom)};
            else              rom[a] = {4'($urandom_range(1, 14)), 12'($urandom)};
         end
         do_reset();
         p = 8'h00;
         for (int i = 0; i < 30; i++) begin
            w = rom[p];
            expect_fetch("rnd_fetch", p);
            if (w[15:12] == 4'h0) begin
               pc_inc = 1'($urandom); jmp_en = 1'($urandom);
               jmp_addr = 8'($urandom); done_in = 1'($urandom);
               @(negedge clk);
               check("rnd_nop_load", 32'(instr), 32'h0);
               @(negedge clk);
               pc_inc = 1'b0; jmp_en = 1'b0; done_in = 1'b0;
               p = p + 8'd1;
            end else if (w[15:12] == 4'hf) begin
               @(negedge clk);
               @(negedge clk);
               check("rnd_halted", 32'(halted), 32'd1);
               check("rnd_halt_rd", 32'(mem_rd), 32'd0);
               @(negedge clk);
               check("rnd_halt_pc", 32'(pc), 32'(p));
               break;
            end else begin
               n  = $urandom_range(1, 6);
               m  = 16'($urandom);
               jc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
               ja = 8'($urandom);
               run_exec("rnd", p, w, n, m, jc, ja);
               p = model_pc(p, n, m, jc, ja);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
